// File: rtl/decoder_2_4_stream.sv
// Registered 2-to-4 decoder with valid/ready handshake and a 2-entry output skid buffer.
// Optional saturating invalid-word counter on err_count when DECODER_ERR_CNT_EN is defined.
module decoder_2_4_stream #(
    parameter  int unsigned IDX_W = 2,
    localparam int unsigned OUT_W = 2**IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] d_in,
    input  logic             invalid_input,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] d_out,
    output logic             out_invalid,
    output logic             out_valid,
    input  logic             out_ready
`ifdef DECODER_ERR_CNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic             inv;
        logic [OUT_W-1:0] word;
    } entry_t;

    state_t state;
    state_t state_next;
    entry_t head;
    entry_t head_next;
    entry_t tail;
    entry_t tail_next;
    entry_t in_entry;
    logic   valid_q;
    logic   valid_next;
    logic   accept;
    logic   pop;

    // Decode happens at accept so stored entries are already one-hot.
    always_comb begin
        in_entry.inv  = invalid_input;
        in_entry.word = invalid_input ? '0 : (OUT_W'(1) << d_in);
    end

    assign in_ready = (state != TWO);
    assign accept   = in_valid && in_ready;
    assign pop      = valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            head    <= '0;
            tail    <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            head    <= head_next;
            tail    <= tail_next;
            valid_q <= valid_next;
        end
    end

    // Entry 0 (head) drives the outputs; entry 1 only fills under backpressure.
    always_comb begin
        state_next = state;
        head_next  = head;
        tail_next  = tail;
        valid_next = valid_q;
        case (state)
            EMPTY: begin
                if (accept) begin
                    head_next  = in_entry;
                    state_next = ONE;
                    valid_next = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_next = in_entry;
                end else if (accept) begin
                    tail_next  = in_entry;
                    state_next = TWO;
                end else if (pop) begin
                    state_next = EMPTY;
                    valid_next = 1'b0;
                end
            end
            TWO: begin
                if (pop) begin
                    head_next  = tail;
                    state_next = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
                valid_next = 1'b0;
            end
        endcase
    end

    assign d_out       = head.word;
    assign out_invalid = head.inv;
    assign out_valid   = valid_q;

`ifdef DECODER_ERR_CNT_EN
    localparam int unsigned ERR_W = 8;

    logic [ERR_W-1:0] err_q;

    // Saturating count of accepted invalid words; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (accept && invalid_input && (err_q != '1)) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_decoder_2_4_stream.sv
// Scoreboard bench for decoder_2_4_stream; define DECODER_ERR_CNT_EN to also check err_count.
module tb_decoder_2_4_stream;

    logic       clk;
    logic       rst_n;
    logic [1:0] d_in;
    logic       invalid_input;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] d_out;
    logic       out_invalid;
    logic       out_valid;
    logic       out_ready;
`ifdef DECODER_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    typedef struct packed {
        logic       inv;
        logic [3:0] word;
    } exp_t;

    exp_t q[$];
    int   n_cmp;
    int   n_err;
    int   exp_err;

    decoder_2_4_stream #(.IDX_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .d_in          (d_in),
        .invalid_input (invalid_input),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .d_out         (d_out),
        .out_invalid   (out_invalid),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
`ifdef DECODER_ERR_CNT_EN
        ,
        .err_count     (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle at negedge, then check occupancy model and scoreboard before the posedge.
    task automatic step(input logic v, input logic [1:0] d, input logic inv, input logic ordy);
        logic acc;
        logic pp;
        exp_t e;
        @(negedge clk);
        in_valid      = v;
        d_in          = d;
        invalid_input = inv;
        out_ready     = ordy;
        #1;
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
`ifdef DECODER_ERR_CNT_EN
        check("err_count", 32'(err_count), 32'(exp_err));
`endif
        acc = v && in_ready;
        pp  = out_valid && ordy;
        if (pp && q.size() != 0) begin
            e = q.pop_front();
            check("d_out", 32'(d_out), 32'(e.word));
            check("out_invalid", 32'(out_invalid), 32'(e.inv));
        end
        if (acc) begin
            e.inv  = inv;
            e.word = inv ? 4'b0000 : (4'(1) << d);
            q.push_back(e);
            if (inv && exp_err < 255) exp_err++;
        end
    endtask

    task automatic reset_mid();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d_out", 32'(d_out), 32'd0);
        check("rst_out_invalid", 32'(out_invalid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        exp_err = 0;
`ifdef DECODER_ERR_CNT_EN
        check("rst_err_count", 32'(err_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        exp_err       = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        d_in          = 2'd0;
        invalid_input = 1'b0;
        out_ready     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_d_out", 32'(d_out), 32'd0);
        check("reset_out_invalid", 32'(out_invalid), 32'd0);
        rst_n = 1'b1;

        // Full-rate stream of all four indices
        for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1);

        // Invalid word: zero output, flag set
        step(1'b1, 2'd2, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1);

        // Backpressure: fill both entries, third word waits, X on d_in while full
        step(1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b1, 2'bxx, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b1);
        step(1'b1, 2'd3, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1);

        // Simultaneous accept and pop in ONE
        step(1'b1, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1);

        // Reset while holding two words
        step(1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b1, 2'd2, 1'b0, 1'b0);
        reset_mid();
        step(1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b1, 2'd1, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1);

        // Long invalid stream drives the error counter into saturation
        for (int i = 0; i < 300; i++) step(1'b1, 2'(i), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, 1'b1);

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));

        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
